// File: rtl/framebuffer_scanout_if.sv
// rtl/framebuffer_scanout_if.sv - framebuffer read-port bundle between scanout (master) and memory (slave)
interface framebuffer_scanout_if #(
    parameter int BITS_PER_PIXEL = 3
) ();
    logic                      Read_Enable;
    logic [31:0]               Read_Addr;
    logic [BITS_PER_PIXEL-1:0] Read_Data;

    modport master (output Read_Enable, output Read_Addr, input  Read_Data);
    modport slave  (input  Read_Enable, input  Read_Addr, output Read_Data);
endinterface

// File: rtl/framebuffer_scanout.sv
// rtl/framebuffer_scanout.sv - raster timing, sequential framebuffer reads and aligned video output
// Optional colour-bar generator enabled by FRAMEBUFFER_SCANOUT_TEST_PATTERN_EN.
module framebuffer_scanout #(
    parameter int BITS_PER_PIXEL = 3,
    parameter int H_VISIBLE      = 640,
    parameter int H_FRONT        = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BACK         = 48,
    parameter int V_VISIBLE      = 480,
    parameter int V_FRONT        = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BACK         = 33,
    parameter int READ_LATENCY   = 1
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset,
    framebuffer_scanout_if.master     rd,
    input  logic                      i_Test_Pattern,
    output logic [BITS_PER_PIXEL-1:0] o_Pixel,
    output logic                      o_HSync,
    output logic                      o_VSync,
    output logic                      o_Active,
    output logic                      o_Frame_Start
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int L       = READ_LATENCY;
    localparam int BPP     = BITS_PER_PIXEL;

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [31:0]   addr_q, addr_d;
    logic          h_last, v_last, vis, hs_n, vs_n, fs;

    always_comb begin
        h_last = (h_q == HW'(H_TOTAL - 1));
        v_last = (v_q == VW'(V_TOTAL - 1));
        vis    = (h_q < HW'(H_VISIBLE)) && (v_q < VW'(V_VISIBLE));
        hs_n   = !((h_q >= HW'(H_VISIBLE + H_FRONT)) && (h_q < HW'(H_VISIBLE + H_FRONT + H_SYNC)));
        vs_n   = !((v_q >= VW'(V_VISIBLE + V_FRONT)) && (v_q < VW'(V_VISIBLE + V_FRONT + V_SYNC)));
        fs     = (h_q == '0) && (v_q == '0);
        h_d    = h_last ? '0 : h_q + 1'b1;
        v_d    = v_q;
        if (h_last) begin
            v_d = v_last ? '0 : v_q + 1'b1;
        end
        // Address restarts on the frame wrap, otherwise tracks visible clocks only.
        addr_d = addr_q;
        if (h_last && v_last) begin
            addr_d = '0;
        end else if (vis) begin
            addr_d = addr_q + 32'd1;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            h_q    <= '0;
            v_q    <= '0;
            addr_q <= '0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            addr_q <= addr_d;
        end
    end

    logic                 rd_en_q, rd_en_d;
    logic [31:0]          rd_addr_q;
    logic [L:0]           vis_pipe_q, hs_pipe_q, vs_pipe_q, fs_pipe_q;
    logic [BPP-1:0]       pix_q, pix_d;
    logic                 hs_q, vs_q, act_q, fs_q;

`ifdef FRAMEBUFFER_SCANOUT_TEST_PATTERN_EN
    logic [31:0]          bar;
    logic [BPP-1:0]       tp_pix;
    logic [L:0]           tp_sel_pipe_q;
    logic [L:0][BPP-1:0]  tp_pix_pipe_q;

    always_comb begin
        bar     = (32'(h_q) << 3) / 32'(H_VISIBLE);
        tp_pix  = BPP'(bar[2:0]);
        rd_en_d = vis && !i_Test_Pattern;
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            tp_sel_pipe_q <= '0;
            tp_pix_pipe_q <= '0;
        end else begin
            tp_sel_pipe_q <= {tp_sel_pipe_q[L-1:0], i_Test_Pattern};
            tp_pix_pipe_q <= {tp_pix_pipe_q[L-1:0], tp_pix};
        end
    end
`else
    logic unused_test_pattern;
    assign unused_test_pattern = i_Test_Pattern;
    assign rd_en_d             = vis;
`endif

    always_comb begin
        pix_d = '0;
        if (vis_pipe_q[L]) begin
            pix_d = rd.Read_Data;
`ifdef FRAMEBUFFER_SCANOUT_TEST_PATTERN_EN
            if (tp_sel_pipe_q[L]) begin
                pix_d = tp_pix_pipe_q[L];
            end
`endif
        end
    end

    // Index 0 of each pipe is the read-strobe stage; index L lines up with returning data.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            vis_pipe_q <= '0;
            hs_pipe_q  <= '1;
            vs_pipe_q  <= '1;
            fs_pipe_q  <= '0;
            pix_q      <= '0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            act_q      <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            rd_en_q    <= rd_en_d;
            if (vis) begin
                rd_addr_q <= addr_q;
            end
            vis_pipe_q <= {vis_pipe_q[L-1:0], vis};
            hs_pipe_q  <= {hs_pipe_q[L-1:0], hs_n};
            vs_pipe_q  <= {vs_pipe_q[L-1:0], vs_n};
            fs_pipe_q  <= {fs_pipe_q[L-1:0], fs};
            pix_q      <= pix_d;
            hs_q       <= hs_pipe_q[L];
            vs_q       <= vs_pipe_q[L];
            act_q      <= vis_pipe_q[L];
            fs_q       <= fs_pipe_q[L];
        end
    end

    assign rd.Read_Enable = rd_en_q;
    assign rd.Read_Addr   = rd_addr_q;
    assign o_Pixel        = pix_q;
    assign o_HSync        = hs_q;
    assign o_VSync        = vs_q;
    assign o_Active       = act_q;
    assign o_Frame_Start  = fs_q;
endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb/tb_framebuffer_scanout.sv - self-checking bench for framebuffer_scanout on an 8x6 raster
module tb_framebuffer_scanout;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tp  = 1'b0;
    logic [2:0] pix;
    logic       hs, vs, act, fs;

    framebuffer_scanout_if #(.BITS_PER_PIXEL(3)) rd_if ();

    framebuffer_scanout #(
        .BITS_PER_PIXEL(3),
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .READ_LATENCY(1)
    ) dut (
        .i_Clock(clk),
        .i_Reset(rst),
        .rd(rd_if),
        .i_Test_Pattern(tp),
        .o_Pixel(pix),
        .o_HSync(hs),
        .o_VSync(vs),
        .o_Active(act),
        .o_Frame_Start(fs)
    );

    always #5 clk = ~clk;

    // Memory model: addr[2:0] one clock after a strobe, random junk otherwise.
    always @(posedge clk) begin
        if (rd_if.Read_Enable) rd_if.Read_Data <= rd_if.Read_Addr[2:0];
        else                   rd_if.Read_Data <= 3'($urandom);
    end

    int errors = 0;
    int checks = 0;
    int k = 0;
    bit tp_mode = 1'b0;
    bit stats_on = 1'b0;
    int strobes = 0, vs_low = 0, hs_low = 0;
    logic [31:0] addrq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at k=%0d", tag, obs, exp, k);
        end
    endtask

    // Reference: cycle kk after reset release; counters hold position kk mod 48.
    task automatic check_all(input int kk);
        int p, h, v;
        bit visible;
        int e_en, e_addr, e_pix, e_hs, e_vs, e_act, e_fs;
        e_en = 0; e_addr = 0;
        if (kk >= 1) begin
            p = (kk - 1) % 48; h = p % 8; v = p / 8;
            visible = (h < 4) && (v < 3);
            e_en   = (visible && !tp_mode) ? 1 : 0;
            e_addr = visible ? v * 4 + h : ((v < 3) ? v * 4 + 3 : 11);
        end
        e_pix = 0; e_hs = 1; e_vs = 1; e_act = 0; e_fs = 0;
        if (kk >= 3) begin
            p = (kk - 3) % 48; h = p % 8; v = p / 8;
            visible = (h < 4) && (v < 3);
            e_act = visible ? 1 : 0;
            if (visible) e_pix = tp_mode ? (h * 8 / 4) % 8 : (v * 4 + h) % 8;
            e_hs  = (h >= 5 && h < 7) ? 0 : 1;
            e_vs  = (v == 4) ? 0 : 1;
            e_fs  = (p == 0) ? 1 : 0;
        end
        check("read_enable", 32'(rd_if.Read_Enable), 32'(e_en));
        check("read_addr",   rd_if.Read_Addr,        32'(e_addr));
        check("pixel",       32'(pix),               32'(e_pix));
        check("hsync",       32'(hs),                32'(e_hs));
        check("vsync",       32'(vs),                32'(e_vs));
        check("active",      32'(act),               32'(e_act));
        check("frame_start", 32'(fs),                32'(e_fs));
    endtask

    task automatic step();
        @(posedge clk);
        k++;
        @(negedge clk);
        check_all(k);
        if (stats_on) begin
            if (k >= 1 && k <= 48 && rd_if.Read_Enable) begin
                strobes++;
                addrq.push_back(rd_if.Read_Addr);
            end
            if (k >= 3 && k <= 50) begin
                if (!vs) vs_low++;
                if (!hs) hs_low++;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Asynchronous mid-cycle reset: outputs must drop to reset values without a clock edge.
    task automatic do_reset(input int n);
        #1 rst = 1'b1;
        #1 k = 0;
        check_all(0);
        repeat (n) @(posedge clk);
        @(negedge clk);
        check_all(0);
        rst = 1'b0;
        #1 check_all(0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all(0);
        rst = 1'b0;
        k = 0;
        #1 check_all(0);

        stats_on = 1'b1;
        run(51);
        stats_on = 1'b0;
        check("strobes_per_frame", 32'(strobes), 32'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < addrq.size()) check("strobe_addr_order", addrq[i], 32'(i));
            else                  check("strobe_addr_missing", 32'hFFFF_FFFF, 32'(i));
        end
        check("vsync_low_clocks", 32'(vs_low), 32'd8);
        check("hsync_low_clocks", 32'(hs_low), 32'd12);
        run(45);

        while ((k % 48) != 10) step();
        do_reset(3);
        run(55);

        for (int r = 0; r < 5; r++) begin
            run($urandom_range(120, 5));
            do_reset($urandom_range(3, 1));
        end
        run(100);

`ifdef FRAMEBUFFER_SCANOUT_TEST_PATTERN_EN
        #1 rst = 1'b1;
        tp = 1'b1;
        tp_mode = 1'b1;
        do_reset(2);
        run(100);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
